// File: rtl/pll_lock_supervisor_if.sv
// ----------------------------------------------------------------------------
// pll_lock_supervisor_if: PLL control/status bundle between supervisor and PLL
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface pll_lock_supervisor_if;
  logic       locked;
  logic       relock_req;
  logic       fault_clr;
  logic       pll_rst;
  logic       clk_ready;
  logic       lock_lost;
  logic       fault;
  logic [7:0] retry_count;
  logic [2:0] state;

  // master: the supervisor, which drives the PLL reset and the status outputs
  modport master (
    input  locked, relock_req, fault_clr,
    output pll_rst, clk_ready, lock_lost, fault, retry_count, state
  );

  // slave: the PLL and the surrounding system
  modport slave (
    output locked, relock_req, fault_clr,
    input  pll_rst, clk_ready, lock_lost, fault, retry_count, state
  );
endinterface

`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
// ----------------------------------------------------------------------------
// pll_lock_supervisor: PLL reset/lock sequencer with timeout, retry and fault latch
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES = 24,
  parameter int LOCK_TIMEOUT   = 24000,
  parameter int STABLE_CYCLES  = 2400,
  parameter int MAX_RETRIES    = 4,
  parameter int CNT_W          = 16
) (
  input  wire logic              refclk,
  input  wire logic              rst_n,
  pll_lock_supervisor_if.master  bus
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

  state_t           cur_state;
  state_t           next_state;
  logic [CNT_W-1:0] timer;
  logic             timer_clr;
  logic [7:0]       retry_cnt;
  logic [7:0]       retry_next;
  logic             retry_fail;
  logic             sync_meta;
  logic             locked_s;
  logic             pll_rst_q;
  logic             clk_ready_q;
  logic             lock_lost_q;
  logic             fault_q;

  // locked comes straight from the PLL with no relation to refclk
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      sync_meta <= bus.locked;
      locked_s  <= sync_meta;
    end
  end

  always_comb begin
    next_state = cur_state;
    timer_clr  = 1'b0;
    retry_next = retry_cnt;
    retry_fail = 1'b0;

    case (cur_state)
      RESET_PLL: begin
        if (timer == RST_LAST) begin
          next_state = WAIT_LOCK;
          timer_clr  = 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          next_state = STABLE;
          timer_clr  = 1'b1;
        end else if (timer == TIMEOUT_LAST) begin
          retry_fail = 1'b1;
        end
      end
      STABLE: begin
        // A short drop during qualification is a glitch, not a failed attempt
        if (!locked_s) begin
          next_state = WAIT_LOCK;
          timer_clr  = 1'b1;
        end else if (timer == STABLE_LAST) begin
          next_state = RUN;
          timer_clr  = 1'b1;
          retry_next = 8'd0;
        end
      end
      RUN: begin
        timer_clr = 1'b1;
        if (!locked_s) begin
          retry_fail = 1'b1;
        end
      end
      FAULT: begin
        timer_clr = 1'b1;
        if (bus.fault_clr) begin
          next_state = RESET_PLL;
          retry_next = 8'd0;
        end
      end
      default: begin
        next_state = RESET_PLL;
        timer_clr  = 1'b1;
      end
    endcase

    if (retry_fail) begin
      timer_clr = 1'b1;
      if (retry_cnt >= RETRY_LIMIT) begin
        next_state = FAULT;
      end else begin
        next_state = RESET_PLL;
        retry_next = (retry_cnt == 8'hFF) ? retry_cnt : retry_cnt + 8'd1;
      end
    end

    // An explicit relock outranks lock/timeout handling and is never counted
    if (bus.relock_req && (cur_state != FAULT)) begin
      next_state = RESET_PLL;
      timer_clr  = 1'b1;
      retry_next = retry_cnt;
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      cur_state   <= RESET_PLL;
      timer       <= '0;
      retry_cnt   <= 8'd0;
      pll_rst_q   <= 1'b1;
      clk_ready_q <= 1'b0;
      lock_lost_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      cur_state   <= next_state;
      timer       <= timer_clr ? '0 : timer + 1'b1;
      retry_cnt   <= retry_next;
      pll_rst_q   <= (next_state == RESET_PLL) || (next_state == FAULT);
      clk_ready_q <= (next_state == RUN);
      lock_lost_q <= (cur_state == RUN) && !locked_s;
      fault_q     <= (next_state == FAULT);
    end
  end

  assign bus.pll_rst     = pll_rst_q;
  assign bus.clk_ready   = clk_ready_q;
  assign bus.lock_lost   = lock_lost_q;
  assign bus.fault       = fault_q;
  assign bus.retry_count = retry_cnt;
  assign bus.state       = cur_state;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
// ----------------------------------------------------------------------------
// tb_pll_lock_supervisor: directed vector bench for pll_lock_supervisor
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pll_lock_supervisor;

  logic refclk;
  logic rst_n;
  int   checks;
  int   errors;

  pll_lock_supervisor_if bus ();

  pll_lock_supervisor #(
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (20),
    .STABLE_CYCLES  (8),
    .MAX_RETRIES    (2),
    .CNT_W          (16)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  typedef struct {
    logic       rst_n;
    logic       locked;
    logic       relock;
    logic       fclr;
    logic       pll;
    logic       rdy;
    logic       lost;
    logic       flt;
    logic [7:0] rc;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic r, input logic lk, input logic rl, input logic fc,
                     input logic pll, input logic rdy, input logic lost, input logic flt,
                     input logic [7:0] rc, input logic [2:0] st);
    vec_t v;
    v = '{r, lk, rl, fc, pll, rdy, lost, flt, rc, st};
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic expect_out(input string name, input logic pll, input logic rdy, input logic lost,
                            input logic flt, input logic [7:0] rc, input logic [2:0] st);
    logic [14:0] act;
    logic [14:0] exp;
    act = {bus.pll_rst, bus.clk_ready, bus.lock_lost, bus.fault, bus.retry_count, bus.state};
    exp = {pll, rdy, lost, flt, rc, st};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got pll_rst=%b clk_ready=%b lock_lost=%b fault=%b retry=%0d state=%0d, want pll_rst=%b clk_ready=%b lock_lost=%b fault=%b retry=%0d state=%0d",
               name, act[14], act[13], act[12], act[11], act[10:3], act[2:0],
               pll, rdy, lost, flt, rc, st);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n          = 1'b0;
    bus.locked     = 1'b0;
    bus.relock_req = 1'b0;
    bus.fault_clr  = 1'b0;

    // Clean lock: reset, 4-cycle PLL reset, locked raised 5 cycles after pll_rst falls
    add(1, 0, 0, 0, 0,  1, 0, 0, 0, 8'd0, 3'd0);
    add(3, 1, 0, 0, 0,  1, 0, 0, 0, 8'd0, 3'd0);
    add(5, 1, 0, 0, 0,  0, 0, 0, 0, 8'd0, 3'd1);
    add(2, 1, 1, 0, 0,  0, 0, 0, 0, 8'd0, 3'd1);
    add(8, 1, 1, 0, 0,  0, 0, 0, 0, 8'd0, 3'd2);
    add(2, 1, 1, 0, 0,  0, 1, 0, 0, 8'd0, 3'd3);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n          = vecs[i].rst_n;
      bus.locked     = vecs[i].locked;
      bus.relock_req = vecs[i].relock;
      bus.fault_clr  = vecs[i].fclr;
      tick();
      expect_out($sformatf("vec%0d", i), vecs[i].pll, vecs[i].rdy, vecs[i].lost,
                 vecs[i].flt, vecs[i].rc, vecs[i].st);
    end

    // Lock loss in RUN: the synchroniser delays the reaction by two edges
    bus.locked = 1'b0;
    tick(); expect_out("run_hold0",      0, 1, 0, 0, 8'd0, 3'd3);
    tick(); expect_out("run_hold1",      0, 1, 0, 0, 8'd0, 3'd3);
    tick(); expect_out("lost_pulse",     1, 0, 1, 0, 8'd1, 3'd0);
    bus.locked = 1'b1;
    tick(); expect_out("lost_one_cycle", 1, 0, 0, 0, 8'd1, 3'd0);
    tick_n(2);
    tick(); expect_out("relock_wait",    0, 0, 0, 0, 8'd1, 3'd1);
    tick(); expect_out("relock_stable",  0, 0, 0, 0, 8'd1, 3'd2);

    // One-cycle lock glitch seen by the FSM at STABLE timer=5
    tick_n(3);
    bus.locked = 1'b0;
    tick();
    bus.locked = 1'b1;
    tick(); expect_out("glitch_pre",       0, 0, 0, 0, 8'd1, 3'd2);
    tick(); expect_out("glitch_back_wait", 0, 0, 0, 0, 8'd1, 3'd1);
    tick(); expect_out("glitch_restable",  0, 0, 0, 0, 8'd1, 3'd2);
    tick_n(6);
    tick(); expect_out("stable_late",      0, 0, 0, 0, 8'd1, 3'd2);
    tick(); expect_out("run_regained",     0, 1, 0, 0, 8'd0, 3'd3);

    // relock_req coincident with synchronised lock loss
    bus.locked = 1'b0;
    tick();
    tick(); expect_out("run_before_relock", 0, 1, 0, 0, 8'd0, 3'd3);
    bus.relock_req = 1'b1;
    tick(); expect_out("relock_and_loss",   1, 0, 1, 0, 8'd0, 3'd0);
    bus.relock_req = 1'b0;
    tick(); expect_out("relock_no_retry",   1, 0, 0, 0, 8'd0, 3'd0);

    // Timeouts with locked held low lead to FAULT after three attempts
    tick_n(2);
    tick(); expect_out("timeout_wait0", 0, 0, 0, 0, 8'd0, 3'd1);
    tick_n(18);
    tick(); expect_out("wait_last",     0, 0, 0, 0, 8'd0, 3'd1);
    tick(); expect_out("timeout1",      1, 0, 0, 0, 8'd1, 3'd0);
    tick_n(23);
    tick(); expect_out("timeout2",      1, 0, 0, 0, 8'd2, 3'd0);
    tick_n(22);
    tick(); expect_out("wait3_last",    0, 0, 0, 0, 8'd2, 3'd1);
    tick(); expect_out("fault_entry",   1, 0, 0, 1, 8'd2, 3'd4);

    // FAULT ignores locked and relock_req; only fault_clr leaves it
    bus.locked     = 1'b1;
    bus.relock_req = 1'b1;
    tick(); expect_out("fault_ign_relock", 1, 0, 0, 1, 8'd2, 3'd4);
    bus.relock_req = 1'b0;
    tick(); expect_out("fault_ign_lock",   1, 0, 0, 1, 8'd2, 3'd4);
    bus.fault_clr = 1'b1;
    tick(); expect_out("fault_clr",        1, 0, 0, 0, 8'd0, 3'd0);
    bus.fault_clr = 1'b0;

    // Reset pulse while in STABLE restarts the whole sequence
    tick_n(3);
    tick(); expect_out("pre_rst_wait",   0, 0, 0, 0, 8'd0, 3'd1);
    tick(); expect_out("pre_rst_stable", 0, 0, 0, 0, 8'd0, 3'd2);
    tick();
    rst_n = 1'b0;
    tick(); expect_out("mid_reset",      1, 0, 0, 0, 8'd0, 3'd0);
    rst_n = 1'b1;
    tick_n(2);
    tick(); expect_out("restart_rst",    1, 0, 0, 0, 8'd0, 3'd0);
    tick(); expect_out("restart_wait",   0, 0, 0, 0, 8'd0, 3'd1);
    tick(); expect_out("restart_stable", 0, 0, 0, 0, 8'd0, 3'd2);
    tick_n(6);
    tick(); expect_out("restart_late",   0, 0, 0, 0, 8'd0, 3'd2);
    tick(); expect_out("restart_run",    0, 1, 0, 0, 8'd0, 3'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Sequences the 108 MHz video PLL (24 MHz refclk in) from power-up to a stable, usable clock.
- Drives the PLL reset and waits for lock with a timeout.
- Requires lock to stay stable before releasing the downstream video logic.
- Retries on timeout or loss of lock, and latches a fault after repeated failures.
- Runs entirely in the refclk domain, because the PLL output is not trusted until lock.

Parameters:
PLL_RST_CYCLES, 24, refclk cycles pll_rst is held high per attempt (1 us)
LOCK_TIMEOUT, 24000, refclk cycles allowed in WAIT_LOCK before a retry (1 ms)
STABLE_CYCLES, 2400, consecutive refclk cycles of synchronised lock required before RUN (100 us)
MAX_RETRIES, 4, failed attempts tolerated before FAULT
CNT_W, 16, width of the shared phase timer; must hold max(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)

Ports:
refclk  in  1  reference clock, 24 MHz; sole clock of the block
rst_n  in  1  synchronous active-low reset, sampled on refclk rising edge
locked  in  1  PLL locked, asynchronous to refclk
relock_req  in  1  single-cycle pulse; forces a new PLL reset sequence
fault_clr  in  1  single-cycle pulse; leaves FAULT
pll_rst  out  1  to PLL rst, active high
clk_ready  out  1  high only in RUN; downstream logic synchronises it into its own domain as its reset release
lock_lost  out  1  one-cycle pulse when synchronised lock drops in RUN
fault  out  1  high only in FAULT
retry_count  out  8  failed attempts since last RUN entry; saturates at 255
state  out  3  current state encoding, for debug

Behaviour:
- Synchronisation: locked passes through a 2-flop synchroniser to give locked_s (2-cycle latency). Only locked_s is used.
- States and encoding: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4. Moore outputs, all registered.
- Reset (rst_n low at an edge): state=RESET_PLL, timer=0, retry_count=0, synchroniser flops=0, pll_rst=1, clk_ready=0, lock_lost=0, fault=0. A reset mid-sequence, including in RUN or FAULT, restarts from RESET_PLL.
- RESET_PLL: pll_rst=1. Stays exactly PLL_RST_CYCLES cycles (timer 0..PLL_RST_CYCLES-1), then WAIT_LOCK with timer=0.
- WAIT_LOCK: pll_rst=0.
  - locked_s=1 -> STABLE, timer=0.
  - Else, at timer==LOCK_TIMEOUT-1 -> retry action.
- STABLE: pll_rst=0.
  - locked_s=0 -> WAIT_LOCK, timer=0 (glitch; not a retry).
  - At timer==STABLE_CYCLES-1 with locked_s=1 -> RUN; retry_count cleared to 0 on this transition.
- RUN: clk_ready=1. If locked_s=0, lock_lost pulses for exactly one cycle and the retry action is taken.
- Retry action: if retry_count>=MAX_RETRIES -> FAULT; else retry_count+1 (saturating) -> RESET_PLL, timer=0.
- FAULT: pll_rst=1, clk_ready=0, fault=1. Ignores locked and relock_req. fault_clr -> RESET_PLL with retry_count=0.
- relock_req, in any state except FAULT -> RESET_PLL with timer=0. retry_count is unchanged (not a failure).
- Priority per cycle, highest first: rst_n low, then relock_req, then lock/timeout conditions.
- Simultaneous relock_req and lock loss in RUN: lock_lost still pulses; relock path is taken; retry_count is not incremented.
- Timing consequence (locked held high from PLL reset release): clk_ready rises STABLE_CYCLES+2 edges after the first edge at which locked is sampled high in WAIT_LOCK.
- Timer widths: the timer never wraps. It is reset on every state entry, and each compare uses the parameter minus 1 at CNT_W bits.

Test Plan:
All scenarios use sim parameters PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
1. Clean lock: release rst_n; raise locked 5 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; clk_ready rises 10 edges after locked is first sampled; retry_count=0; state=3.
2. Lock glitch in STABLE: drop locked for 1 cycle at STABLE timer=5 -> return to WAIT_LOCK, then STABLE again; clk_ready delayed accordingly; retry_count stays 0.
3. Timeout to fault: locked tied low -> three RESET_PLL/WAIT_LOCK cycles of 4+20 each, retry_count 0->1->2; FAULT entered on the third timeout; fault=1, pll_rst=1. Then pulse fault_clr -> RESET_PLL, retry_count=0.
4. Lock loss in RUN: from RUN drop locked -> lock_lost one-cycle pulse 2 edges later; clk_ready=0 on the same edge; retry_count=1; PLL reset re-sequenced; retry_count=0 after RUN is regained.
5. relock_req in RUN coincident with locked falling -> lock_lost pulses; RESET_PLL; retry_count unchanged. relock_req in FAULT -> no effect.
6. rst_n low for 1 cycle while in STABLE -> all outputs return to reset values at the next edge; full sequence restarts.
